// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pooling stage.
// Takes row-major pixels one per accepted beat and emits pooled pixels in row-major order.
// A half-width row buffer keeps the horizontal pair maxima from each even row.
module pool2x2_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam int unsigned CW     = $clog2(IMG_W);
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned HALF_W = IMG_W / 2;
  localparam int unsigned AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  // Marks that the pending output is the last window of the frame.
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] rbuf [HALF_W];
  logic              rbuf_we;
  logic [AW-1:0]     rbuf_addr;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;
  logic              accept;

  // Handshake outputs; gated by rst so nothing is offered or signalled while in reset.
  always_comb begin
    in_ready  = rst && (!out_valid_q || out_ready);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    done      = rst && out_valid_q && out_ready && out_last_q;
  end

  // Window arithmetic: pair max of the current beat, then fold in the buffered upper pair.
  always_comb begin
    accept    = in_valid && in_ready;
    rbuf_addr = AW'(col_q >> 1);
    pair_max  = smax(hold_q, in_data);
    win_max   = smax(pair_max, rbuf[rbuf_addr]);
  end

  // Next-state: position counters, hold register, row buffer write and output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    rbuf_we     = 1'b0;
    if (start) begin
      // start wins over a beat accepted in the same cycle; pending output is kept.
      col_d  = '0;
      row_d  = '0;
      hold_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        rbuf_we = 1'b1;
      end else begin
        out_data_d  = win_max;
        out_valid_d = 1'b1;
        out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Row buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (rbuf_we) begin
      rbuf[rbuf_addr] <= pair_max;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream: a 4x4 instance for the hand-computed cases and a
// 28x28 instance for two back-to-back random frames against a reference model.
module tb_pool2x2_stream;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [31:0] in_data;

  logic        r4, ov4, dn4;
  logic [31:0] od4;
  logic        r28, ov28, dn28;
  logic [31:0] od28;

  int          n_checks = 0;
  int          n_pass   = 0;

  logic [31:0] q4[$];
  logic [31:0] q28[$];
  int          d4 = 0;
  int          d28 = 0;
  logic [31:0] d4_data;
  int          d28_at[$];

  always #5 clk = ~clk;

  pool2x2_stream #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r4),
    .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .done(dn4)
  );

  pool2x2_stream #(.DATA_W(32), .IMG_W(28), .IMG_H(28)) dut28 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r28),
    .in_data(in_data), .out_valid(ov28), .out_ready(out_ready), .out_data(od28), .done(dn28)
  );

  // Collect accepted outputs and done pulses mid-cycle.
  always @(negedge clk) begin
    if (rst && ov4 && out_ready) q4.push_back(od4);
    if (dn4) begin
      d4++;
      d4_data = od4;
    end
    if (rst && ov28 && out_ready) q28.push_back(od28);
    if (dn28) begin
      d28++;
      d28_at.push_back(q28.size());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q4.delete();
    q28.delete();
    d28_at.delete();
    d4  = 0;
    d28 = 0;
  endtask

  // Present one beat and hold it until accepted by the selected instance.
  task automatic send(input logic [31:0] d, input bit sel28);
    int   waited;
    logic rdy;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    rdy = sel28 ? r28 : r4;
    while (!rdy && waited < 200) begin
      @(negedge clk);
      waited++;
      rdy = sel28 ? r28 : r4;
    end
    if (!rdy) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    tick(); tick();
    n_checks++;
    if ({r4, ov4, dn4, ov28} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000", {r4, ov4, dn4, ov28});
    else n_pass++;
    n_checks++;
    if (od4 !== 32'd0) $display("FAIL reset_data: got %h required 0", od4);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({r4, ov4} !== 2'b10) $display("FAIL post_reset_ready: got %b required 10", {r4, ov4});
    else n_pass++;
  endtask

  task automatic test_ramp();
    logic [31:0] exp4 [4];
    exp4 = '{32'd5, 32'd7, 32'd13, 32'd15};
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      send(32'(i), 1'b0);
      if (i == 4) begin
        n_checks++;
        if (ov4 !== 1'b0) $display("FAIL ramp_early_valid: got %b required 0", ov4);
        else n_pass++;
      end
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        n_checks++;
        if ({ov4, od4} !== {1'b1, 32'(i)})
          $display("FAIL ramp_latency px%0d: got %b/%0d required 1/%0d", i, ov4, od4, i);
        else n_pass++;
      end
    end
    tick(); tick();
    n_checks++;
    if (q4.size() !== 4) $display("FAIL ramp_count: got %0d required 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_checks++;
      if (q4[k] !== exp4[k]) $display("FAIL ramp_out%0d: got %0d required %0d", k, q4[k], exp4[k]);
      else n_pass++;
    end
    n_checks++;
    if (d4 !== 1 || d4_data !== 32'd15)
      $display("FAIL ramp_done: got %0d pulses data %0d required 1 pulse data 15", d4, d4_data);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [31:0] px [16];
    logic [31:0] exp4 [4];
    for (int i = 0; i < 16; i++) px[i] = 32'hFFFF_FF9C;
    px[0] = 32'hFFFF_FFFD; px[1] = 32'hFFFF_FFF8;
    px[4] = 32'hFFFF_FFFF; px[5] = 32'hFFFF_FFEC;
    exp4 = '{32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FF9C};
    clear_obs();
    for (int i = 0; i < 16; i++) send(px[i], 1'b0);
    tick(); tick();
    n_checks++;
    if (q4.size() !== 4) $display("FAIL signed_count: got %0d required 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_checks++;
      if (q4[k] !== exp4[k]) $display("FAIL signed_out%0d: got %h required %h", k, q4[k], exp4[k]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp4 [4];
    exp4 = '{32'd5, 32'd7, 32'd13, 32'd15};
    clear_obs();
    fork
      begin
        for (int i = 0; i < 16; i++) send(32'(i), 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!ov4 && n < 50) begin
          tick();
          n++;
        end
        if (!ov4) begin
          n_checks++;
          $display("FAIL bp_wait: out_valid never rose, required 1");
        end else begin
          out_ready = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ov4, r4, od4} !== {2'b10, 32'd5})
              $display("FAIL bp_hold%0d: got v=%b rdy=%b d=%0d required v=1 rdy=0 d=5",
                       k, ov4, r4, od4);
            else n_pass++;
            tick();
          end
          out_ready = 1'b1;
        end
      end
    join
    tick(); tick();
    n_checks++;
    if (q4.size() !== 4) $display("FAIL bp_count: got %0d required 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_checks++;
      if (q4[k] !== exp4[k]) $display("FAIL bp_out%0d: got %0d required %0d", k, q4[k], exp4[k]);
      else n_pass++;
    end
    n_checks++;
    if (d4 !== 1) $display("FAIL bp_done: got %0d pulses required 1", d4);
    else n_pass++;
  endtask

  task automatic test_midstart();
    logic [31:0] exp4 [4];
    exp4 = '{32'd105, 32'd107, 32'd113, 32'd115};
    for (int i = 0; i < 6; i++) send(32'(i), 1'b0);
    // start together with a live beat: the beat must be dropped.
    start = 1'b1; in_valid = 1'b1; in_data = 32'd999;
    tick();
    start = 1'b0; in_valid = 1'b0;
    tick(); tick();
    clear_obs();
    for (int i = 0; i < 16; i++) send(32'(100 + i), 1'b0);
    tick(); tick();
    n_checks++;
    if (q4.size() !== 4) $display("FAIL start_count: got %0d required 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_checks++;
      if (q4[k] !== exp4[k]) $display("FAIL start_out%0d: got %0d required %0d", k, q4[k], exp4[k]);
      else n_pass++;
    end
    n_checks++;
    if (d4 !== 1) $display("FAIL start_done: got %0d pulses required 1", d4);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp4 [4];
    exp4 = '{32'd5, 32'd7, 32'd13, 32'd15};
    for (int i = 0; i < 10; i++) send(32'(i), 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({r4, ov4, dn4, od4} !== 35'd0)
        $display("FAIL rst_mid%0d: got rdy=%b v=%b done=%b d=%0d required all 0",
                 k, r4, ov4, dn4, od4);
      else n_pass++;
    end
    rst = 1'b1;
    tick();
    clear_obs();
    for (int i = 0; i < 16; i++) send(32'(i), 1'b0);
    tick(); tick();
    n_checks++;
    if (q4.size() !== 4) $display("FAIL rst_count: got %0d required 4", q4.size());
    else n_pass++;
    for (int k = 0; k < 4 && k < q4.size(); k++) begin
      n_checks++;
      if (q4[k] !== exp4[k]) $display("FAIL rst_out%0d: got %0d required %0d", k, q4[k], exp4[k]);
      else n_pass++;
    end
  endtask

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  task automatic test_back_to_back();
    logic [31:0] frm [2*784];
    logic [31:0] exp28 [392];
    bit          feed_done;
    for (int i = 0; i < 2*784; i++) frm[i] = $urandom();
    for (int f = 0; f < 2; f++)
      for (int wr = 0; wr < 14; wr++)
        for (int wc = 0; wc < 14; wc++) begin
          int b;
          b = f*784 + 2*wr*28 + 2*wc;
          exp28[f*196 + wr*14 + wc] = ref_max(ref_max(frm[b], frm[b+1]),
                                              ref_max(frm[b+28], frm[b+29]));
        end
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    clear_obs();
    feed_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 2*784; p++) begin
          repeat ($urandom_range(0, 2)) tick();
          send(frm[p], 1'b1);
        end
        feed_done = 1'b1;
      end
      begin
        while (!feed_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 200 && q28.size() < 392; n++) tick();
    n_checks++;
    if (q28.size() !== 392) $display("FAIL b2b_count: got %0d required 392", q28.size());
    else n_pass++;
    for (int k = 0; k < 392 && k < q28.size(); k++) begin
      n_checks++;
      if (q28[k] !== exp28[k])
        $display("FAIL b2b_out%0d: got %h required %h", k, q28[k], exp28[k]);
      else n_pass++;
    end
    n_checks++;
    if (d28 !== 2) $display("FAIL b2b_done_count: got %0d required 2", d28);
    else n_pass++;
    if (d28_at.size() == 2) begin
      n_checks++;
      if (d28_at[0] !== 196 || d28_at[1] !== 392)
        $display("FAIL b2b_done_pos: got %0d,%0d required 196,392", d28_at[0], d28_at[1]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_backpressure();
    test_midstart();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
